fp_norm_round_pack: RTL
=======================

// Module: fp_norm_round_pack
// PURPOSE
// Back end of the IEEE-754 single-precision adder. Consumes the 28-bit raw sum mantissa and its
// leading-zero count from the zero-count stage, then normalises, rounds to nearest-even and packs
// the 32-bit result. Two pipeline stages (normalise, round/pack) with valid/ready flow control on
// both sides; sustains one result per clock when not stalled.
// PARAMETERS
// EXP_W   8    exponent field width
// MAN_W   28   raw mantissa width: [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S
// PORTS
// clk             in   1   clock, rising edge
// rst_n           in   1   asynchronous reset, active low
// in_valid        in   1   input beat valid
// in_ready        out  1   block can accept a beat this cycle
// in_sign         in   1   result sign
// in_exp          in   8   biased exponent of bit [26]; denormal operands are presented as 1
// in_mant         in   28  raw sum mantissa
// in_zcount       in   5   leading-zero count of in_mant (0..28)
// in_special      in   1   NaN/Inf/bypass result already known
// in_special_val  in   32  packed result used when in_special=1
// out_valid       out  1   result valid
// out_ready       in   1   downstream accepts the result
// out_result      out  32  packed IEEE-754 single-precision result
// out_overflow    out  1   result rounded to +/-Inf from finite operands
// out_underflow   out  1   result is denormal or zero AND inexact (G|R|S nonzero after normalisation)
// BEHAVIOUR
// - Reset: s1_valid, out_valid, out_result, out_overflow, out_underflow = 0. Reset while beats are
//   in flight discards them; no partial output appears after rst_n deasserts.
// - Handshake: a beat transfers when valid&&ready. Stage 2 loads when !out_valid || out_ready.
//   in_ready = !s1_valid || stage-2 load. in_ready does not depend on in_valid. Outputs hold stable
//   while out_valid && !out_ready. Latency is 2 clocks from input transfer to out_valid. Order is kept.
// - Stage 1 (normalise). Internal exponent is 10-bit signed e.
//   zcount==28: result is zero; pack sign=in_sign, exp=0, frac=0; flags 0.
//   zcount==0: shift right 1. New S = S | old bit0. e = in_exp+1.
//   zcount==1: no shift; e = in_exp.
//   zcount>=2: k = min(zcount-1, in_exp-1). Shift left by k. e = in_exp-k.
//   After the shift, if bit[26]==0 the exponent field is 0 (denormal).
// - Stage 2 (round, RNE): LSB=[3], G=[2], R=[1], S=[0].
//   Round up iff G && (R||S||LSB). Add 1 at [3] into 24 bits {[26:3]}.
//   If the increment carries out: mantissa becomes 0x800000 and exp+1.
//   A denormal that rounds into bit[26] becomes exp field 1.
// - Overflow: if final e>=255, the result is {sign,8'hFF,23'h0} and out_overflow=1.
// - in_special=1: the beat bypasses the arithmetic. out_result=in_special_val and flags are 0.
//   It still takes the 2-clock latency and keeps its order.
// - out_result/out_overflow/out_underflow are registered and change only on a stage-2 load.
// TESTING
// 1.0+1.0: sign0 exp127 mant 28'h8000000 zc0 -> 0x40000000, flags 0, out_valid 2 clk after accept
// cancellation: exp127 mant 28'h0000008 zc24 -> 0x34000000 (2^-23), flags 0
// ties: exp127 mant 28'h4000004 zc1 -> 0x3F800000; mant 28'h400000C -> 0x3F800002
// overflow: exp254 mant 28'hFFFFFF8 zc0 -> 0x7F800000, out_overflow=1
// denormal: exp1 mant 28'h2000000 zc2 -> 0x00400000, underflow 0
//   same with mant 28'h2000004 -> 0x00400000, underflow 1
// backpressure: out_ready=0, 3 beats offered -> 2 accepted, in_ready=0, out_result stable;
//   out_ready=1 -> all 3 results emerge in order
// reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, no stale beat afterwards
// special: in_special=1 with 0x7FC00000 interleaved between normal beats -> 0x7FC00000 in order

Source files
------------

// File: rtl/fp_norm_round_pack.sv
// Single-precision adder back end: normalise the raw sum, round to nearest-even and pack.
// Two registered stages with valid/ready flow control on both sides.
module fp_norm_round_pack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [MAN_W-1:0]     in_mant,
  input  logic [4:0]           in_zcount,
  input  logic                 in_special,
  input  logic [EXP_W+23:0]    in_special_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+23:0]    out_result,
  output logic                 out_overflow,
  output logic                 out_underflow
);

  localparam int unsigned E_W    = EXP_W + 2;
  localparam int unsigned NM_W   = MAN_W - 1;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = FRAC_W + 1;
  localparam int unsigned ZC_W   = 5;
  localparam int unsigned RES_W  = 1 + EXP_W + FRAC_W;
  localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

  // Stage 1 pipeline registers
  logic                    s1_valid;
  logic                    s1_sign;
  logic signed [E_W-1:0]   s1_e;
  logic [NM_W-1:0]         s1_m;
  logic                    s1_zero;
  logic                    s1_special;
  logic [RES_W-1:0]        s1_special_val;

  logic s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Normalise: shift so bit 26 is the hidden bit, clamping at the denormal exponent
  logic signed [E_W-1:0] exp_s;
  logic signed [E_W-1:0] zc_m1;
  logic signed [E_W-1:0] exp_m1;
  logic signed [E_W-1:0] shift_k;
  logic signed [E_W-1:0] norm_e;
  logic [NM_W-1:0]       norm_m;
  logic                  norm_zero;

  always_comb begin
    exp_s     = signed'(E_W'(in_exp));
    zc_m1     = signed'(E_W'(in_zcount) - E_W'(1));
    exp_m1    = exp_s - signed'(E_W'(1));
    shift_k   = (zc_m1 < exp_m1) ? zc_m1 : exp_m1;
    norm_zero = (in_zcount == ZC_W'(MAN_W));
    norm_m    = in_mant[NM_W-1:0];
    norm_e    = exp_s;
    if (shift_k[E_W-1]) begin
      shift_k = '0;
    end
    if (in_zcount == '0) begin
      // Carry set: shift right one, folding the dropped bit into sticky
      norm_m = {in_mant[MAN_W-1:2], in_mant[1] | in_mant[0]};
      norm_e = exp_s + signed'(E_W'(1));
    end else if (in_zcount != ZC_W'(1)) begin
      norm_m = in_mant[NM_W-1:0] << shift_k[ZC_W-1:0];
      norm_e = exp_s - shift_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_sign        <= 1'b0;
      s1_e           <= '0;
      s1_m           <= '0;
      s1_zero        <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_val <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign        <= in_sign;
        s1_e           <= norm_e;
        s1_m           <= norm_m;
        s1_zero        <= norm_zero;
        s1_special     <= in_special;
        s1_special_val <= in_special_val;
      end
    end
  end

  // Round to nearest-even on [26:3] and assemble the packed word
  logic [SIG_W-1:0]      sig;
  logic [SIG_W:0]        sig_rnd;
  logic                  rnd_up;
  logic                  inexact;
  logic                  is_normal;
  logic signed [E_W-1:0] fin_e;
  logic [EXP_W-1:0]      exp_field;
  logic [FRAC_W-1:0]     frac;
  logic [RES_W-1:0]      res_c;
  logic                  ovf_c;
  logic                  ufl_c;

  always_comb begin
    sig       = s1_m[NM_W-1:3];
    rnd_up    = s1_m[2] & (s1_m[1] | s1_m[0] | s1_m[3]);
    inexact   = |s1_m[2:0];
    sig_rnd   = {1'b0, sig} + (SIG_W+1)'(rnd_up);
    fin_e     = s1_e;
    frac      = sig_rnd[FRAC_W-1:0];
    if (sig_rnd[SIG_W]) begin
      fin_e = s1_e + signed'(E_W'(1));
      frac  = '0;
    end
    // A denormal that rounds into the hidden bit already carries exponent 1
    is_normal = sig_rnd[SIG_W] | sig_rnd[SIG_W-1];
    exp_field = is_normal ? fin_e[EXP_W-1:0] : '0;
    ovf_c     = is_normal && (fin_e >= EXP_MAX);
    ufl_c     = !is_normal && inexact;
    res_c     = {s1_sign, exp_field, frac};
    if (ovf_c) begin
      res_c = {s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
    if (s1_zero) begin
      res_c = {s1_sign, {(RES_W-1){1'b0}}};
      ovf_c = 1'b0;
      ufl_c = 1'b0;
    end
    if (s1_special) begin
      res_c = s1_special_val;
      ovf_c = 1'b0;
      ufl_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= res_c;
        out_overflow  <= ovf_c;
        out_underflow <= ufl_c;
      end
    end
  end

endmodule
